uart_word_tx: RTL and testbench
===============================

UART_WORD_TX -- requirements
Module: uart_word_tx

Interface
REQ-001 The block SHALL have parameter WORD_W, default 128: input word width in bits, a multiple of 8, minimum 8.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4: number of words buffered, a power of 2, minimum 2.
REQ-003 The block SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per UART bit, minimum 2.
REQ-004 The block SHALL have parameter PARITY_EN, default 0: 1 inserts a parity bit after the data bits.
REQ-005 The block SHALL have parameter PARITY_ODD, default 0: 0 selects even parity and 1 selects odd parity; it is ignored when PARITY_EN=0.
REQ-006 The block SHALL have parameter STOP_BITS, default 1: number of stop bits, 1 or 2.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-008 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-009 The block SHALL have port in_data, input, WORD_W bits: word to transmit.
REQ-010 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-011 The block SHALL have port in_ready, output, 1 bit: the FIFO is not full.
REQ-012 The block SHALL have port tx, output, 1 bit: the UART serial line, idle high.
REQ-013 The block SHALL have port busy, output, 1 bit: the FSM is not IDLE.
REQ-014 The block SHALL have port fifo_count, output, clog2(FIFO_DEPTH)+1 bits: number of words buffered.
REQ-015 The block SHALL have port word_done, output, 1 bit: a one-cycle pulse after the last stop bit of a word.

Function
REQ-016 A word SHALL be accepted on a rising clk edge where in_valid=1 and in_ready=1; in_ready SHALL equal (fifo_count != FIFO_DEPTH) and SHALL have no combinational path from in_valid.
REQ-017 A push and a pop in the same cycle SHALL leave fifo_count unchanged; a push while full SHALL be impossible by handshake; the FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-018 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-019 In IDLE with fifo_count>0, the FSM SHALL pop the head word into the shift register on that edge, set the byte index to 0 and enter START; tx SHALL go low starting the next cycle.
REQ-020 Each state SHALL hold for CLKS_PER_BIT cycles per bit using a baud counter that reloads at each bit boundary.
REQ-021 START SHALL drive tx=0 for one bit time.
REQ-022 DATA SHALL drive 8 bits, LSB first.
REQ-023 PARITY SHALL be entered only when PARITY_EN=1 and SHALL drive the XOR of the 8 data bits, inverted when PARITY_ODD=1.
REQ-024 STOP SHALL drive tx=1 for STOP_BITS bit times.
REQ-025 Bytes SHALL be sent from byte 0 (in_data[7:0]) up to byte WORD_W/8-1, each framed with its own start, data, parity and stop bits.
REQ-026 After STOP of a byte that is not the last, the FSM SHALL go directly to START of the next byte with no idle gap.
REQ-027 After STOP of the last byte, word_done SHALL pulse for one cycle and the FSM SHALL enter IDLE; the next word SHALL start per REQ-019, giving exactly one idle-high cycle between words.
REQ-028 The line time of one word SHALL be (WORD_W/8) x (10 + PARITY_EN + STOP_BITS - 1) x CLKS_PER_BIT cycles.
REQ-029 tx SHALL be driven from a flop to be glitch-free.
REQ-030 busy SHALL be 0 only in IDLE.
REQ-031 Words SHALL be transmitted in acceptance order, with no loss or duplication.

Reset
REQ-032 When reset is asserted, the block SHALL immediately force tx=1, busy=0, word_done=0, fifo_count=0 and in_ready=1, and put the FSM in IDLE with all counters at 0.
REQ-033 A reset asserted mid-frame SHALL abort the frame and discard all FIFO contents; no partial byte SHALL resume after reset is released.
REQ-034 The first push SHALL be accepted on the first clk edge after reset deasserts.

Structure
REQ-035 Package uart_pkg SHALL hold the FSM state enum (IDLE/START/DATA/PARITY/STOP) and the constants PARITY_EVEN=0 and PARITY_ODD=1.
REQ-036 The block SHALL have one sub-module, uart_word_fifo: a synchronous FIFO parametrised by WORD_W and FIFO_DEPTH, with push/pop/count; uart_word_tx SHALL contain the FSM, baud counter, bit counter, byte index and shift register.

Verification (WORD_W=16, CLKS_PER_BIT=4, FIFO_DEPTH=4 unless stated)
REQ-037 Reset test: assert reset -> tx=1, in_ready=1, fifo_count=0, busy=0 during reset and on the first cycle after.
REQ-038 Single word test: push 16'hA55A -> tx reads 0,0,1,0,1,1,0,1,0,1 (byte 0x5A), then 0,1,0,1,0,0,1,0,1,1 (byte 0xA5), each bit 4 cycles; 80 cycles total; one word_done pulse.
REQ-039 Parity test: PARITY_EN=1 with byte 0x5A -> even parity bit 0, and odd parity (PARITY_ODD=1) bit 1; frame 11 bits = 44 cycles per byte.
REQ-040 Backpressure test: push 5 words back-to-back (16'h0001..16'h0005) with in_valid held -> in_ready drops at fifo_count=4, resumes after the first pop; 5 word_done pulses in order 1..5.
REQ-041 Mid-frame reset test: assert reset in the DATA state of byte 0 with 3 words queued -> tx=1 immediately, fifo_count=0; no word_done pulse after release.
REQ-042 STOP_BITS=2 test: the stop phase is high for 8 cycles per byte; word time is 88 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared FSM state type and parity selector constants for the UART word transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int PARITY_EVEN = 0;
  localparam int PARITY_ODD  = 1;

  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_word_fifo.sv
// Synchronous word FIFO: head visible combinationally, one-cycle push/pop latency.
// Push is ignored when full and pop when empty; pointers wrap modulo DEPTH.
module uart_word_fifo #(
  parameter int WORD_W = 128,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WORD_W-1:0]        i_push_dat,
  input  logic                     i_pop,
  output logic [WORD_W-1:0]        o_head_dat,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr;
  logic [PTR_W-1:0]  r_rd;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full     = (r_count == CNT_W'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_head_dat = r_mem[r_rd];
  assign w_push     = i_push & ~o_full;
  assign w_pop      = i_pop & ~o_empty;

  // Storage needs no reset: reset empties the FIFO through the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= i_push_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_word_tx.sv
// Buffers WORD_W-bit words and serialises them LSB byte first as UART frames on a flopped tx.
// First start bit one cycle after the pop; in_ready drops only while the FIFO is full.
module uart_word_tx #(
  parameter int WORD_W       = 128,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [WORD_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          word_done
);

  import uart_pkg::*;

  localparam int   NBYTES = WORD_W / 8;
  localparam int   BI_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int   BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic ODD    = (PARITY_ODD == uart_pkg::PARITY_ODD);

  state_t             r_state;
  logic [BAUD_W-1:0]  r_baud;
  logic [3:0]         r_bit;
  logic [BI_W-1:0]    r_byte;
  logic [WORD_W-1:0]  r_sh;
  logic               r_par;
  logic               r_tx;
  logic               r_done;

  logic [WORD_W-1:0]  w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_bit_end;
  logic               w_last_byte;

  assign w_push      = in_valid & ~w_full;
  assign w_pop       = (r_state == IDLE) & ~w_empty;
  assign w_bit_end   = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
  assign w_last_byte = (r_byte == BI_W'(NBYTES - 1));

  assign in_ready  = ~w_full;
  assign tx        = r_tx;
  assign busy      = (r_state != IDLE);
  assign word_done = r_done;

  uart_word_fifo #(
    .WORD_W (WORD_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (reset),
    .i_push     (w_push),
    .i_push_dat (in_data),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_count    (fifo_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_sh    <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != IDLE) begin
        r_baud <= w_bit_end ? '0 : r_baud + BAUD_W'(1);
      end
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_sh    <= w_head;
            r_byte  <= '0;
            r_bit   <= '0;
            r_baud  <= '0;
            r_par   <= parity_bit(w_head[7:0], ODD);
            r_tx    <= 1'b0;
            r_state <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_tx    <= r_sh[0];
            r_bit   <= '0;
            r_state <= DATA;
          end
        end
        DATA: begin
          // The word shifts one bit per data bit, so after 8 the next byte sits at the bottom.
          if (w_bit_end) begin
            r_sh <= r_sh >> 1;
            if (r_bit == 4'd7) begin
              r_bit <= '0;
              if (PARITY_EN != 0) begin
                r_tx    <= r_par;
                r_state <= PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= STOP;
              end
            end else begin
              r_bit <= r_bit + 4'd1;
              r_tx  <= r_sh[1];
            end
          end
        end
        PARITY: begin
          if (w_bit_end) begin
            r_tx    <= 1'b1;
            r_bit   <= '0;
            r_state <= STOP;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            if (r_bit == 4'(STOP_BITS - 1)) begin
              r_bit <= '0;
              if (w_last_byte) begin
                r_done  <= 1'b1;
                r_state <= IDLE;
              end else begin
                r_byte  <= r_byte + BI_W'(1);
                r_par   <= parity_bit(r_sh[7:0], ODD);
                r_tx    <= 1'b0;
                r_state <= START;
              end
            end else begin
              r_bit <= r_bit + 4'd1;
            end
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// Four transmitters (plain, even parity, odd parity, two stop bits) checked by a line-decoding scoreboard.
module tb_uart_word_tx;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int CPB = 4;
  localparam logic [N-1:0] PEN  = 4'b0110;
  localparam logic [N-1:0] PODD = 4'b0100;
  localparam logic [N-1:0] SB2  = 4'b1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] rst_v;
  logic [N-1:0] vld_v;
  logic [W-1:0] dat_a [N];
  wire  [N-1:0] rdy_v;
  wire  [N-1:0] tx_v;
  wire  [N-1:0] busy_v;
  wire  [N-1:0] done_v;
  wire  [2:0]   cnt_a [N];

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_dut
      uart_word_tx #(
        .WORD_W       (W),
        .FIFO_DEPTH   (4),
        .CLKS_PER_BIT (CPB),
        .PARITY_EN    (int'(PEN[g])),
        .PARITY_ODD   (int'(PODD[g])),
        .STOP_BITS    (SB2[g] ? 2 : 1)
      ) u_dut (
        .clk        (clk),
        .reset      (rst_v[g]),
        .in_data    (dat_a[g]),
        .in_valid   (vld_v[g]),
        .in_ready   (rdy_v[g]),
        .tx         (tx_v[g]),
        .busy       (busy_v[g]),
        .fifo_count (cnt_a[g]),
        .word_done  (done_v[g])
      );
    end
  endgenerate

  logic [W-1:0] exp_q [N][$];
  int st_q  [N][$];
  int dur_q [N][$];
  int par_q [N][$];
  int pulses   [N];
  int done_exp [N];
  int cyc  = 0;
  int nchk = 0;
  int nerr = 0;

  task automatic check(input string name, input int k, input longint act, input longint exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, k, act, exp);
    end
  endtask

  // Reference line waveform: one entry per bit time, built directly from the frame format.
  function automatic void build_seq(input int k, input logic [W-1:0] w,
                                    output logic [47:0] seq, output int n);
    logic [7:0] by;
    seq = '1;
    n   = 0;
    for (int b = 0; b < W / 8; b++) begin
      by = w[b*8 +: 8];
      seq[n] = 1'b0; n++;
      for (int j = 0; j < 8; j++) begin
        seq[n] = by[j]; n++;
      end
      if (PEN[k]) begin
        seq[n] = (^by) ^ PODD[k]; n++;
      end
      for (int s = 0; s < (SB2[k] ? 2 : 1); s++) begin
        seq[n] = 1'b1; n++;
      end
    end
  endfunction

  task automatic mon(input int k);
    logic [W-1:0] w, dec;
    logic [47:0]  seq;
    logic         pbit;
    int n, fb, mism, s0, b, pos, byt;
    bit aborted;
    fb = 10 + int'(PEN[k]) + (SB2[k] ? 2 : 1) - 1;
    forever begin
      @(negedge clk);
      if (rst_v[k] || tx_v[k]) continue;
      check("queue_has_word", k, exp_q[k].size() > 0, 1);
      if (exp_q[k].size() == 0) continue;
      w = exp_q[k].pop_front();
      build_seq(k, w, seq, n);
      mism = 0; dec = '0; pbit = 1'b0; aborted = 1'b0; s0 = cyc;
      for (int i = 0; i < n * CPB; i++) begin
        if (i > 0) @(negedge clk);
        if (rst_v[k]) begin
          aborted = 1'b1;
          break;
        end
        if (tx_v[k] !== seq[i/CPB] || done_v[k] !== 1'b0) mism++;
        if (i % CPB == CPB / 2) begin
          b = i / CPB; byt = b / fb; pos = b % fb;
          if (pos >= 1 && pos <= 8) dec[byt*8 + pos - 1] = tx_v[k];
          if (pos == 9 && PEN[k] && byt == 0) pbit = tx_v[k];
        end
      end
      if (aborted) continue;
      check("frame_wave", k, mism, 0);
      check("frame_data", k, dec, w);
      @(negedge clk);
      if (rst_v[k]) continue;
      check("word_done", k, {done_v[k], tx_v[k]}, 2'b11);
      done_exp[k]++;
      st_q[k].push_back(s0);
      dur_q[k].push_back(cyc - s0);
      par_q[k].push_back(int'(pbit));
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < N; k++) begin
      if (!rst_v[k] && vld_v[k] && rdy_v[k]) exp_q[k].push_back(dat_a[k]);
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (!rst_v[k] && done_v[k]) pulses[k]++;
    end
  end

  task automatic send(input int k, input logic [W-1:0] d, output int waits);
    logic rdy;
    vld_v[k] = 1'b1;
    dat_a[k] = d;
    waits = 0;
    forever begin
      rdy = rdy_v[k];
      @(negedge clk);
      if (rdy) break;
      waits++;
      if (waits > 500) begin
        check("send_timeout", k, waits, 0);
        break;
      end
    end
  endtask

  task automatic drain(input int k);
    int t = 0;
    while (!(exp_q[k].size() == 0 && !busy_v[k] && cnt_a[k] == 3'd0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("drain", k, t < 2000, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic rand_burst(input int k);
    int w;
    for (int i = 0; i < 5; i++) begin
      send(k, 16'($urandom), w);
      vld_v[k] = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain(k);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, got time %0t required below 500us", $time);
    nerr++;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $fatal(1, "watchdog");
  end

  initial begin
    int w, t, sb, p0, lowcnt;
    logic prev;
    rst_v = '1;
    vld_v = '0;
    for (int k = 0; k < N; k++) begin
      dat_a[k] = '0;
      pulses[k] = 0;
      done_exp[k] = 0;
    end
    fork
      mon(0); mon(1); mon(2); mon(3);
    join_none
    repeat (2) @(negedge clk);
    for (int k = 0; k < N; k++)
      check("reset_state", k, {tx_v[k], rdy_v[k], busy_v[k], done_v[k], cnt_a[k]}, 7'b1100_000);

    // Release reset and push on the very first edge afterwards.
    rst_v = '0;
    send(0, 16'hA55A, w);
    vld_v[0] = 1'b0;
    check("first_push", 0, w, 0);
    check("post_reset", 0, {tx_v[0], rdy_v[0], busy_v[0], done_v[0], cnt_a[0]}, 7'b1100_001);
    for (int k = 1; k < N; k++)
      check("post_reset", k, {tx_v[k], rdy_v[k], busy_v[k], done_v[k], cnt_a[k]}, 7'b1100_000);
    drain(0);
    check("word_time_80", 0, dur_q[0][$], 80);

    send(1, 16'h5A5A, w); vld_v[1] = 1'b0;
    send(2, 16'h5A5A, w); vld_v[2] = 1'b0;
    send(3, 16'hA55A, w); vld_v[3] = 1'b0;
    for (int k = 1; k < N; k++) drain(k);
    check("even_parity_bit", 1, par_q[1][$], 0);
    check("odd_parity_bit",  2, par_q[2][$], 1);
    check("parity_time_88",  1, dur_q[1][$], 88);
    check("parity_time_88",  2, dur_q[2][$], 88);
    check("stop2_time_88",   3, dur_q[3][$], 88);

    fork
      rand_burst(0); rand_burst(1); rand_burst(2); rand_burst(3);
    join

    // Back-to-back burst fills the FIFO; ready returns right after the next pop.
    sb = st_q[0].size();
    p0 = pulses[0];
    for (int d = 1; d <= 5; d++) send(0, 16'(d), w);
    vld_v[0] = 1'b0;
    check("full_at_4", 0, {rdy_v[0], cnt_a[0]}, 4'b0100);
    prev = 1'b0; t = 0;
    while (!rdy_v[0] && t < 500) begin
      prev = done_v[0];
      @(negedge clk);
      t++;
    end
    check("ready_after_pop", 0, {t < 500, prev}, 2'b11);
    drain(0);
    check("burst_pulses", 0, pulses[0] - p0, 5);
    check("gap_one_idle", 0, st_q[0][sb+1] - st_q[0][sb], 81);

    // Abort a frame in the data phase of byte 0 with three words still queued.
    for (int d = 1; d <= 4; d++) send(0, {8'(d * 17), 8'h00}, w);
    vld_v[0] = 1'b0;
    check("queued_3", 0, cnt_a[0], 3);
    repeat (6) @(negedge clk);
    check("in_data_phase", 0, {busy_v[0], tx_v[0]}, 2'b10);
    @(posedge clk);
    #1;
    rst_v[0] = 1'b1;
    exp_q[0].delete();
    #1;
    check("reset_immediate", 0, {tx_v[0], rdy_v[0], busy_v[0], cnt_a[0]}, 6'b110_000);
    repeat (2) @(negedge clk);
    rst_v[0] = 1'b0;
    p0 = pulses[0];
    lowcnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (!tx_v[0]) lowcnt++;
    end
    check("no_resume", 0, {lowcnt, pulses[0] - p0}, 0);

    for (int k = 0; k < N; k++) check("pulse_count", k, pulses[k], done_exp[k]);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
